sd_blk_dma: RTL

- APB master that sits directly upstream of the SD-SPI APB peripheral. It drives that peripheral's register interface to fetch one SD block into system memory without CPU polling.
- Sequence per transfer: issue the read-block command, poll the peripheral status until the SPI engine is idle, read BLOCK_BYTES bytes one at a time from the peripheral's block buffer, pack them little-endian into 32-bit words, and write the words through a simple ready/valid memory write port.
- Read direction only (SD to memory).

---
 rtl/sd_blk_dma.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/sd_blk_dma.sv
`default_nettype none
// ============================================================================
// Module      : sd_blk_dma
// Description : APB master that fetches one SD block from the SD-SPI APB
//               peripheral. It issues the read command, polls status until
//               the SPI engine is idle, reads the block buffer byte by byte,
//               packs bytes little-endian into 32-bit words and writes them
//               through a ready/valid memory write port.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_blk_dma #(
    parameter int          W_ADDR      = 32,
    parameter logic [15:0] CMD_ADDR    = 16'h8000,
    parameter logic [15:0] BUF_ADDR    = 16'h8200,
    parameter int          BLOCK_BYTES = 512,
    parameter logic [31:0] POLL_MAX    = 32'd1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       blk_addr,
    input  logic [W_ADDR-1:0] mem_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [3:0]        err_code,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [15:0]       paddr,
    output logic [31:0]       pwdata,
    input  logic [31:0]       prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              mem_we,
    output logic [W_ADDR-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready
);

    localparam logic [2:0]  S_IDLE = 3'd0;
    localparam logic [2:0]  S_CMD  = 3'd1;
    localparam logic [2:0]  S_POLL = 3'd2;
    localparam logic [2:0]  S_RD   = 3'd3;
    localparam logic [2:0]  S_MW   = 3'd4;
    localparam logic [2:0]  S_DONE = 3'd5;

    localparam logic [15:0] C_LAST_IDX = 16'(BLOCK_BYTES - 1);

    logic [2:0]        r_state;
    logic [31:0]       r_blk;
    logic [W_ADDR-1:0] r_base;
    logic [15:0]       r_idx;
    logic [31:0]       r_poll_cnt;
    logic [31:0]       r_pack;

    logic [31:0]       w_pack_next;
    logic [31:0]       w_poll_next;
    logic              w_stat_ready;
    logic [W_ADDR-1:0] w_word_off;

    // Status bits and base low bits that carry no meaning for this engine.
    logic              w_unused_ok;
    assign w_unused_ok = &{1'b0, prdata[31:24], prdata[19:17], prdata[15:8], mem_base[1:0]};

    assign w_poll_next  = r_poll_cnt + 32'd1;
    assign w_stat_ready = ~prdata[16] & (prdata[7:0] == 8'd0);
    assign w_word_off   = W_ADDR'({r_idx[15:2], 2'b00});

    // Merge the byte returned by the current buffer read into its lane.
    always_comb begin
        w_pack_next = r_pack;
        w_pack_next[{r_idx[1:0], 3'b000} +: 8] = prdata[7:0];
    end

    // Transfer sequencer; APB and memory port outputs are all registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_blk      <= '0;
            r_base     <= '0;
            r_idx      <= '0;
            r_poll_cnt <= '0;
            r_pack     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 4'd0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_blk      <= blk_addr;
                        r_base     <= {mem_base[W_ADDR-1:2], 2'b00};
                        r_idx      <= '0;
                        r_poll_cnt <= '0;
                        r_pack     <= '0;
                        err        <= 1'b0;
                        err_code   <= 4'd0;
                        busy       <= 1'b1;
                        r_state    <= S_CMD;
                    end
                end
                S_CMD, S_POLL, S_RD: begin
                    if (!psel) begin
                        // SETUP phase; entered only after at least one idle cycle.
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        pwrite  <= (r_state == S_CMD);
                        pwdata  <= (r_state == S_CMD) ? r_blk : 32'd0;
                        paddr   <= (r_state == S_RD) ? (BUF_ADDR + r_idx) : CMD_ADDR;
                    end else if (!penable) begin
                        penable <= 1'b1;
                    end else if (pready) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        pwrite  <= 1'b0;
                        pwdata  <= 32'd0;
                        if (pslverr) begin
                            err      <= 1'b1;
                            err_code <= 4'b1000;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            r_state  <= S_DONE;
                        end else if (r_state == S_CMD) begin
                            r_state <= S_POLL;
                        end else if (r_state == S_POLL) begin
                            r_poll_cnt <= w_poll_next;
                            if (prdata[20]) begin
                                err      <= 1'b1;
                                err_code <= {1'b0, prdata[23:21]};
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                r_state  <= S_DONE;
                            end else if (w_stat_ready) begin
                                r_state <= S_RD;
                            end else if (w_poll_next == POLL_MAX) begin
                                err      <= 1'b1;
                                err_code <= 4'b1000;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                r_state  <= S_DONE;
                            end
                        end else begin
                            r_pack <= w_pack_next;
                            if (r_idx[1:0] == 2'd3) begin
                                mem_we    <= 1'b1;
                                mem_addr  <= r_base + w_word_off;
                                mem_wdata <= w_pack_next;
                                r_state   <= S_MW;
                            end else begin
                                r_idx <= r_idx + 16'd1;
                            end
                        end
                    end
                end
                S_MW: begin
                    if (mem_ready) begin
                        mem_we <= 1'b0;
                        if (r_idx == C_LAST_IDX) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 16'd1;
                            r_state <= S_RD;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
